// File: rtl/ad_dual_capture.sv
// rtl/ad_dual_capture.sv - dual-channel ADC capture with threshold trigger and read-back buffer
// Optional: define ADC_DECIM_EN to store only the trigger sample and every DECIM-th cycle after it.
module ad_dual_capture #(
    parameter int DEPTH = 256,
    parameter int AW    = 8,
    parameter int DECIM = 4
) (
    input  logic        clk_20M,
    input  logic        rst,
    input  logic [9:0]  ad_data1,
    input  logic [9:0]  ad_data2,
    input  logic        OTR1,
    input  logic        OTR2,
    input  logic        arm,
    input  logic        trig_ch,
    input  logic        trig_auto,
    input  logic [9:0]  trig_level,
    output logic        busy,
    output logic        done,
    input  logic        rd_en,
    output logic        rd_valid,
    output logic [19:0] rd_data,
    output logic        rd_last,
    output logic [15:0] otr_cnt1,
    output logic [15:0] otr_cnt2
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT_TRIG, S_CAPTURE, S_READY} state_t;

    if ((DEPTH != (1 << AW)) || (DECIM < 2) || (DECIM > 255)) begin : g_bad_param
        $error("ad_dual_capture: inconsistent DEPTH/AW/DECIM");
    end

    state_t          r_state, w_next;
    logic [9:0]      r_cur1, r_cur2, r_prev1, r_prev2;
    logic            r_cur_otr1, r_cur_otr2;
    logic            r_trig_ch, r_trig_auto;
    logic [9:0]      r_trig_level;
    logic [AW-1:0]   r_wr_ptr, r_rd_ptr;
    logic            r_rd_all;
    logic            r_rd_valid, r_rd_last;
    logic [19:0]     r_rd_data;
    logic [15:0]     r_otr_cnt1, r_otr_cnt2;
    logic [19:0]     r_ram [DEPTH];

    logic [9:0]      w_sel_prev, w_sel_cur;
    logic            w_trig, w_store, w_wr, w_last_wr, w_arm_ok, w_rd_fire, w_rd_end;
    logic [AW-1:0]   w_wr_addr;

    assign w_sel_prev = r_trig_ch ? r_prev2 : r_prev1;
    assign w_sel_cur  = r_trig_ch ? r_cur2  : r_cur1;
    assign w_trig     = (r_state == S_WAIT_TRIG) &&
                        (r_trig_auto || ((w_sel_prev < r_trig_level) && (w_sel_cur >= r_trig_level)));

`ifdef ADC_DECIM_EN
    logic [7:0] r_dec_cnt;
    logic       w_dec_hit;

    assign w_dec_hit = (r_dec_cnt == 8'(DECIM - 1));
    assign w_store   = (r_state == S_CAPTURE) && w_dec_hit;

    // Counts cycles since the trigger so that every DECIM-th one is kept.
    always_ff @(posedge clk_20M or posedge rst) begin
        if (rst)
            r_dec_cnt <= '0;
        else if (w_trig || (r_state == S_CAPTURE && w_dec_hit))
            r_dec_cnt <= '0;
        else if (r_state == S_CAPTURE)
            r_dec_cnt <= r_dec_cnt + 8'd1;
    end
`else
    assign w_store = (r_state == S_CAPTURE);
`endif

    assign w_wr      = w_trig || w_store;
    assign w_wr_addr = w_trig ? '0 : r_wr_ptr;
    assign w_last_wr = w_store && (r_wr_ptr == AW'(DEPTH - 1));
    assign w_arm_ok  = arm && ((r_state == S_IDLE) || (r_state == S_READY));
    assign w_rd_fire = (r_state == S_READY) && rd_en && !arm && !r_rd_all;
    assign w_rd_end  = (r_rd_ptr == AW'(DEPTH - 1));

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:      if (arm) w_next = S_WAIT_TRIG;
            S_WAIT_TRIG: if (w_trig) w_next = S_CAPTURE;
            S_CAPTURE:   if (w_last_wr) w_next = S_READY;
            S_READY: begin
                if (arm)
                    w_next = S_WAIT_TRIG;
                else if (r_rd_valid && r_rd_last)
                    w_next = S_IDLE;
            end
            default:     w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_20M or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cur1       <= '0;
            r_cur2       <= '0;
            r_prev1      <= '0;
            r_prev2      <= '0;
            r_cur_otr1   <= 1'b0;
            r_cur_otr2   <= 1'b0;
            r_trig_ch    <= 1'b0;
            r_trig_auto  <= 1'b0;
            r_trig_level <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_rd_all     <= 1'b0;
            r_rd_valid   <= 1'b0;
            r_rd_last    <= 1'b0;
            r_rd_data    <= '0;
            r_otr_cnt1   <= '0;
            r_otr_cnt2   <= '0;
        end else begin
            r_state    <= w_next;
            r_prev1    <= r_cur1;
            r_prev2    <= r_cur2;
            r_cur1     <= ad_data1;
            r_cur2     <= ad_data2;
            r_cur_otr1 <= OTR1;
            r_cur_otr2 <= OTR2;

            if (w_arm_ok) begin
                r_trig_ch    <= trig_ch;
                r_trig_auto  <= trig_auto;
                r_trig_level <= trig_level;
                r_wr_ptr     <= '0;
                r_rd_ptr     <= '0;
                r_rd_all     <= 1'b0;
                r_otr_cnt1   <= '0;
                r_otr_cnt2   <= '0;
            end else begin
                if (w_trig)
                    r_wr_ptr <= AW'(1);
                else if (w_store && !w_last_wr)
                    r_wr_ptr <= r_wr_ptr + AW'(1);
                if (w_wr && r_cur_otr1 && (r_otr_cnt1 != 16'hFFFF))
                    r_otr_cnt1 <= r_otr_cnt1 + 16'd1;
                if (w_wr && r_cur_otr2 && (r_otr_cnt2 != 16'hFFFF))
                    r_otr_cnt2 <= r_otr_cnt2 + 16'd1;
            end

            // rd_data keeps the last delivered word while rd_valid is low.
            r_rd_valid <= w_rd_fire;
            r_rd_last  <= w_rd_fire && w_rd_end;
            if (w_rd_fire) begin
                r_rd_data <= r_ram[r_rd_ptr];
                if (w_rd_end)
                    r_rd_all <= 1'b1;
                else
                    r_rd_ptr <= r_rd_ptr + AW'(1);
            end
        end
    end

    always_ff @(posedge clk_20M) begin
        if (w_wr)
            r_ram[w_wr_addr] <= {r_cur2, r_cur1};
    end

    assign busy     = (r_state == S_WAIT_TRIG) || (r_state == S_CAPTURE);
    assign done     = (r_state == S_READY);
    assign rd_valid = r_rd_valid;
    assign rd_data  = r_rd_data;
    assign rd_last  = r_rd_last;
    assign otr_cnt1 = r_otr_cnt1;
    assign otr_cnt2 = r_otr_cnt2;

endmodule

// File: tb/tb_ad_dual_capture.sv
// tb/tb_ad_dual_capture.sv - directed self-checking bench for ad_dual_capture (DEPTH=16)
module tb_ad_dual_capture;

`ifdef ADC_DECIM_EN
    localparam int STEP    = 4;
    localparam int BUSYN   = 61;
    localparam int OTR1EXP = 1;
`else
    localparam int STEP    = 1;
    localparam int BUSYN   = 16;
    localparam int OTR1EXP = 3;
`endif

    logic        clk_20M = 1'b0;
    logic        rst;
    logic [9:0]  ad_data1, ad_data2, trig_level;
    logic        OTR1, OTR2, arm, trig_ch, trig_auto, rd_en;
    logic        busy, done, rd_valid, rd_last;
    logic [19:0] rd_data;
    logic [15:0] otr_cnt1, otr_cnt2;

    int n_pass  = 0;
    int n_total = 0;
    bit ramp_en = 1'b0;
    int busy_cnt;

    ad_dual_capture #(.DEPTH(16), .AW(4), .DECIM(4)) dut (
        .clk_20M(clk_20M), .rst(rst), .ad_data1(ad_data1), .ad_data2(ad_data2),
        .OTR1(OTR1), .OTR2(OTR2), .arm(arm), .trig_ch(trig_ch), .trig_auto(trig_auto),
        .trig_level(trig_level), .busy(busy), .done(done), .rd_en(rd_en),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last),
        .otr_cnt1(otr_cnt1), .otr_cnt2(otr_cnt2)
    );

    always #25 clk_20M = ~clk_20M;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic cyc();
        @(posedge clk_20M);
        #1;
        if (ramp_en)
            ad_data1 = ad_data1 + 10'd1;
    endtask

    task automatic wait_done();
        for (int k = 0; k < 200 && !done; k++)
            cyc();
        chk("capture_done", 32'(done), 32'd1);
    endtask

    task automatic read_all(input logic [9:0] ch2, input logic [9:0] base);
        logic [9:0] e1;
        for (int i = 0; i < 16; i++) begin
            rd_en = 1'b1;
            cyc();
            e1 = base + 10'(i * STEP);
            chk("rd_valid", 32'(rd_valid), 32'd1);
            chk("rd_data", 32'(rd_data), 32'({ch2, e1}));
            chk("rd_last", 32'(rd_last), 32'(i == 15));
            if (i == 15)
                chk("done_at_last", 32'(done), 32'd1);
        end
        rd_en = 1'b0;
        cyc();
        chk("rd_valid_after", 32'(rd_valid), 32'd0);
        chk("done_after", 32'(done), 32'd0);
        chk("rd_data_hold", 32'(rd_data), 32'({ch2, base + 10'(15 * STEP)}));
    endtask

    initial begin
        rst = 1'b1; ad_data1 = '0; ad_data2 = 10'h155; OTR1 = 0; OTR2 = 0;
        arm = 0; trig_ch = 0; trig_auto = 0; trig_level = '0; rd_en = 0;
        #10;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        chk("rst_otr", 32'({otr_cnt1, otr_cnt2}), 32'd0);
        cyc();
        cyc();
        rst = 1'b0;
        cyc();

        // auto trigger on a ch1 ramp, OTR1 for three stored samples, stray arm mid-capture
        trig_auto = 1'b1; arm = 1'b1; OTR1 = 1'b1; ad_data1 = '0; ramp_en = 1'b1;
        busy_cnt = 0;
        for (int k = 0; k < 200 && !done; k++) begin
            cyc();
            if (busy)
                busy_cnt++;
            if (k == 0) arm = 1'b0;
            if (k == 2) OTR1 = 1'b0;
            if (k == 7) arm = 1'b1;
            if (k == 8) arm = 1'b0;
        end
        chk("t1_done", 32'(done), 32'd1);
        chk("t1_busy_cycles", 32'(busy_cnt), 32'(BUSYN));
        chk("t1_otr1", 32'(otr_cnt1), 32'(OTR1EXP));
        chk("t1_otr2", 32'(otr_cnt2), 32'd0);
        read_all(10'h155, 10'd0);

        // level trigger on ch2 rising through 512
        trig_auto = 1'b0; trig_ch = 1'b1; trig_level = 10'd512; OTR2 = 1'b1;
        ad_data2 = 10'd500; arm = 1'b1;
        cyc();
        arm = 1'b0;
        chk("t2_otr1_cleared", 32'(otr_cnt1), 32'd0);
        chk("t2_busy", 32'(busy), 32'd1);
        ad_data2 = 10'd510;
        cyc();
        ad_data2 = 10'd520;
        wait_done();
        chk("t2_otr2", 32'(otr_cnt2), 32'd16);
        chk("t2_otr1", 32'(otr_cnt1), 32'd0);
        for (int i = 0; i < 5; i++) begin
            rd_en = 1'b1;
            cyc();
            chk("t2_rd_valid", 32'(rd_valid), 32'd1);
            chk("t2_ch2", 32'(rd_data[19:10]), 32'd520);
        end

        // reset in READY after five reads
        rd_en = 1'b0; rst = 1'b1;
        #2;
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_done", 32'(done), 32'd0);
        chk("t5_rd_valid", 32'(rd_valid), 32'd0);
        chk("t5_rd_data", 32'(rd_data), 32'd0);
        chk("t5_otr2", 32'(otr_cnt2), 32'd0);
        cyc();
        rst = 1'b0; OTR2 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rd_en = 1'b1;
            cyc();
            chk("t5_no_read", 32'(rd_valid), 32'd0);
        end
        rd_en = 1'b0;
        trig_auto = 1'b1; ad_data1 = 10'd100; ad_data2 = 10'd7; arm = 1'b1;
        cyc();
        arm = 1'b0;
        wait_done();
        read_all(10'd7, 10'd100);

        // threshold 0 can never fire
        trig_auto = 1'b0; trig_ch = 1'b0; trig_level = '0; arm = 1'b1;
        cyc();
        arm = 1'b0;
        for (int i = 0; i < 30; i++)
            cyc();
        chk("lvl0_busy", 32'(busy), 32'd1);
        chk("lvl0_done", 32'(done), 32'd0);

        rst = 1'b1;
        cyc();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
